// File: rtl/temp_poll_sched_pkg.sv
// Shared definitions for the DS18B20 temperature poll scheduler.
// Holds the FSM state encoding, the default interval/timeout lengths
// and the width of the shared cycle counter. It also provides the
// terminal-count compare that both timed waits use.
package temp_poll_sched_pkg;

    localparam int CNT_W            = 24;
    localparam int INTERVAL_CYC_DEF = 9_000_000;
    localparam int TIMEOUT_CYC_DEF  = 200_000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        WAIT_RD_HI = 3'd2,
        WAIT_RD_LO = 3'd3,
        WAIT_CONV  = 3'd4
    } state_t;

    // True on the last cycle of a wait that is 'lim' cycles long.
    function automatic logic cnt_at_last(input logic [CNT_W-1:0] cnt,
                                         input logic [CNT_W-1:0] lim);
        return (cnt == (lim - CNT_W'(1)));
    endfunction

endpackage

// File: rtl/temp_poll_sched.sv
// Periodic poll scheduler for a DS18B20 controller.
// Starts a controller transaction, waits for the scratchpad read to
// finish (ds_read_state 1 -> 0), captures the temperature and then
// waits INTERVAL_CYC clocks before the next start. A transaction that
// does not complete within TIMEOUT_CYC clocks flags err_timeout and the
// next completion is dropped, since the scratchpad may still hold the
// stale power-on value.
// Ports:
//   CLK_10MHZ       in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   enable          in   periodic polling enable
//   force_req       in   one-shot transaction request (IDLE only)
//   ds_start        out  start pulse to the controller
//   ds_read_state   in   controller scratchpad-read flag
//   ds_temperature  in   controller temperature word (9 bits)
//   temp_out        out  last accepted temperature
//   temp_stb        out  one-cycle pulse when temp_out updates
//   temp_valid      out  temp_out holds a real sample
//   err_timeout     out  sticky: last transaction timed out
//   sample_cnt      out  accepted sample count (wraps)
//   busy            out  high whenever not IDLE
module temp_poll_sched
    import temp_poll_sched_pkg::*;
#(
    parameter int unsigned INTERVAL_CYC = INTERVAL_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
    input  logic       CLK_10MHZ,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       force_req,
    output logic       ds_start,
    input  logic       ds_read_state,
    input  logic [8:0] ds_temperature,
    output logic [8:0] temp_out,
    output logic       temp_stb,
    output logic       temp_valid,
    output logic       err_timeout,
    output logic [7:0] sample_cnt,
    output logic       busy
);

    localparam logic [CNT_W-1:0] INTERVAL_LIM = CNT_W'(INTERVAL_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(TIMEOUT_CYC);

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               rd_prev_r;
    logic               discard_r;
    logic               complete_s;
    logic               timeout_s;
    logic               accept_s;
    logic               ds_start_r;
    logic               busy_r;
    logic [8:0]         temp_out_r;
    logic               temp_stb_r;
    logic               temp_valid_r;
    logic               err_timeout_r;
    logic [7:0]         sample_cnt_r;

    // Completion, timeout and acceptance qualifiers; completion wins a tie.
    always_comb begin
        complete_s = (state_r == WAIT_RD_LO) && rd_prev_r && !ds_read_state;
        timeout_s  = ((state_r == WAIT_RD_HI) || (state_r == WAIT_RD_LO))
                     && cnt_at_last(cnt_r, TIMEOUT_LIM) && !complete_s;
        accept_s   = complete_s && !discard_r;
    end

    // Next-state and shared counter logic.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r + CNT_W'(1);
        case (state_r)
            IDLE: begin
                cnt_next_s = {CNT_W{1'b0}};
                if (enable || force_req) begin
                    next_state_s = START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                cnt_next_s   = {CNT_W{1'b0}};
                next_state_s = WAIT_RD_HI;
            end
            WAIT_RD_HI: begin
                if (timeout_s) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    next_state_s = WAIT_CONV;
                end else if (ds_read_state) begin
                    next_state_s = WAIT_RD_LO;
                end else begin
                    next_state_s = WAIT_RD_HI;
                end
            end
            WAIT_RD_LO: begin
                if (complete_s || timeout_s) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    next_state_s = WAIT_CONV;
                end else begin
                    next_state_s = WAIT_RD_LO;
                end
            end
            WAIT_CONV: begin
                if (cnt_at_last(cnt_r, INTERVAL_LIM)) begin
                    cnt_next_s = {CNT_W{1'b0}};
                    if (enable) begin
                        next_state_s = START;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = WAIT_CONV;
                end
            end
            default: begin
                cnt_next_s   = {CNT_W{1'b0}};
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counter and control registers; ds_start/busy follow next state
    // so they are registered yet aligned with the state they describe.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            rd_prev_r  <= 1'b0;
            ds_start_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= cnt_next_s;
            rd_prev_r  <= ds_read_state;
            ds_start_r <= (next_state_s == START);
            busy_r     <= (next_state_s != IDLE);
        end
    end

    // Sample capture, discard tracking and status flags.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            discard_r     <= 1'b1;
            temp_out_r    <= 9'd0;
            temp_stb_r    <= 1'b0;
            temp_valid_r  <= 1'b0;
            err_timeout_r <= 1'b0;
            sample_cnt_r  <= 8'd0;
        end else begin
            temp_stb_r <= accept_s;
            if (timeout_s) begin
                discard_r     <= 1'b1;
                err_timeout_r <= 1'b1;
            end else if (complete_s) begin
                discard_r <= 1'b0;
                if (accept_s) begin
                    err_timeout_r <= 1'b0;
                end else begin
                    err_timeout_r <= err_timeout_r;
                end
            end else begin
                discard_r     <= discard_r;
                err_timeout_r <= err_timeout_r;
            end
            if (accept_s) begin
                temp_out_r   <= ds_temperature;
                temp_valid_r <= 1'b1;
                sample_cnt_r <= sample_cnt_r + 8'd1;
            end else begin
                temp_out_r   <= temp_out_r;
                temp_valid_r <= temp_valid_r;
                sample_cnt_r <= sample_cnt_r;
            end
        end
    end

    assign ds_start    = ds_start_r;
    assign busy        = busy_r;
    assign temp_out    = temp_out_r;
    assign temp_stb    = temp_stb_r;
    assign temp_valid  = temp_valid_r;
    assign err_timeout = err_timeout_r;
    assign sample_cnt  = sample_cnt_r;

endmodule

// File: tb/tb_temp_poll_sched.sv
// Self-checking bench for temp_poll_sched with a behavioural DS18B20
// controller model, a table of transactions and a scoreboard of
// expected accepted samples.
module tb_temp_poll_sched;

    localparam int INTERVAL = 100;
    localparam int TIMEOUT  = 50;

    logic       CLK_10MHZ = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       force_req;
    logic       ds_start;
    logic       ds_read_state;
    logic [8:0] ds_temperature;
    logic [8:0] temp_out;
    logic       temp_stb;
    logic       temp_valid;
    logic       err_timeout;
    logic [7:0] sample_cnt;
    logic       busy;

    temp_poll_sched #(
        .INTERVAL_CYC(INTERVAL),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .CLK_10MHZ     (CLK_10MHZ),
        .rst_n         (rst_n),
        .enable        (enable),
        .force_req     (force_req),
        .ds_start      (ds_start),
        .ds_read_state (ds_read_state),
        .ds_temperature(ds_temperature),
        .temp_out      (temp_out),
        .temp_stb      (temp_stb),
        .temp_valid    (temp_valid),
        .err_timeout   (err_timeout),
        .sample_cnt    (sample_cnt),
        .busy          (busy)
    );

    always #50 CLK_10MHZ = ~CLK_10MHZ;

    int cyc = 0;
    always @(posedge CLK_10MHZ) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] temp;
        int         rise;    // cycle after start to raise read_state, <0 = never
        int         fall;    // cycle after start to drop read_state
        int         en_off;  // cycle after start to drop enable, <0 = never
        bit         accept;
        bit         gap_chk;
    } vec_t;

    typedef struct {
        logic [8:0] temp;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    vec_t       vecs[7];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         conv_ref = 0;
    logic [7:0] exp_cnt  = 8'd0;
    logic [8:0] m_temp   = 9'd0;
    bit         m_valid  = 1'b0;
    bit         m_err    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Advance to the next falling edge and score any sample strobe.
    task automatic step();
        exp_t e;
        @(negedge CLK_10MHZ);
        if (rst_n && temp_stb) begin
            if (sb_q.size() == 0) begin
                check("stb_unexpected", {31'd0, temp_stb}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_temp", {23'd0, temp_out}, {23'd0, e.temp});
                check("sb_cnt", {24'd0, sample_cnt}, {24'd0, e.cnt});
                check("sb_valid", {31'd0, temp_valid}, 32'd1);
            end
        end
    endtask

    task automatic wait_start(input bit gap_chk, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ds_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            bound_fail("start_seen");
        end else if (gap_chk) begin
            check("start_gap", cyc - conv_ref, INTERVAL);
        end
    endtask

    task automatic txn(input vec_t v);
        bit ok;
        bit done;
        wait_start(v.gap_chk, ok);
        if (!ok) return;
        ds_temperature = v.temp;
        if (v.accept) begin
            exp_cnt = exp_cnt + 8'd1;
            sb_q.push_back('{temp: v.temp, cnt: exp_cnt});
        end
        if (v.rise < 0) begin
            done = 1'b0;
            for (int k = 1; k <= TIMEOUT + 20; k++) begin
                step();
                if (k == 1) check("start_pulse", {31'd0, ds_start}, 32'd0);
                if (err_timeout) begin
                    check("timeout_at", k, TIMEOUT + 1);
                    conv_ref = cyc;
                    done = 1'b1;
                    break;
                end
            end
            if (!done) bound_fail("timeout_seen");
            m_err = 1'b1;
        end else begin
            for (int k = 1; k <= v.fall; k++) begin
                step();
                if (k == 1) check("start_pulse", {31'd0, ds_start}, 32'd0);
                if (k == v.en_off) enable = 1'b0;
                if (k == v.rise) ds_read_state = 1'b1;
                if (k == v.fall) ds_read_state = 1'b0;
            end
            step();
            conv_ref = cyc;
            if (v.accept) begin
                m_temp  = v.temp;
                m_valid = 1'b1;
                m_err   = 1'b0;
            end
            check("stb", {31'd0, temp_stb}, {31'd0, v.accept});
            check("temp_out", {23'd0, temp_out}, {23'd0, m_temp});
            check("valid", {31'd0, temp_valid}, {31'd0, m_valid});
            check("err", {31'd0, err_timeout}, {31'd0, m_err});
            step();
            check("stb_width", {31'd0, temp_stb}, 32'd0);
            check("busy_conv", {31'd0, busy}, 32'd1);
        end
    endtask

    // Follow WAIT_CONV into IDLE; optionally poke force_req mid-wait.
    task automatic expect_idle(input bit force_mid);
        int starts;
        starts = 0;
        for (int k = 1; k <= 150; k++) begin
            step();
            if (k == 20 && force_mid) force_req = 1'b1;
            if (k == 21) force_req = 1'b0;
            if (ds_start) starts++;
            if (cyc - conv_ref == INTERVAL - 1) check("busy_before_idle", {31'd0, busy}, 32'd1);
            if (cyc - conv_ref == INTERVAL) check("busy_idle", {31'd0, busy}, 32'd0);
        end
        check("no_restart", starts, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ds_start"}, {31'd0, ds_start}, 32'd0);
        check({tag, "_temp_out"}, {23'd0, temp_out}, 32'd0);
        check({tag, "_temp_stb"}, {31'd0, temp_stb}, 32'd0);
        check({tag, "_temp_valid"}, {31'd0, temp_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, err_timeout}, 32'd0);
        check({tag, "_cnt"}, {24'd0, sample_cnt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit ok;
        vecs[0] = '{temp: 9'h155, rise: 5,  fall: 10, en_off: -1, accept: 1'b0, gap_chk: 1'b0};
        vecs[1] = '{temp: 9'h032, rise: 5,  fall: 10, en_off: -1, accept: 1'b1, gap_chk: 1'b1};
        vecs[2] = '{temp: 9'h000, rise: -1, fall: 0,  en_off: -1, accept: 1'b0, gap_chk: 1'b1};
        vecs[3] = '{temp: 9'h0AA, rise: 3,  fall: 8,  en_off: -1, accept: 1'b0, gap_chk: 1'b1};
        vecs[4] = '{temp: 9'h1F0, rise: 4,  fall: 12, en_off: -1, accept: 1'b1, gap_chk: 1'b1};
        vecs[5] = '{temp: 9'h07F, rise: 2,  fall: 6,  en_off: 4,  accept: 1'b1, gap_chk: 1'b1};
        vecs[6] = '{temp: 9'h1A5, rise: 3,  fall: 7,  en_off: -1, accept: 1'b1, gap_chk: 1'b0};

        rst_n          = 1'b0;
        enable         = 1'b0;
        force_req      = 1'b0;
        ds_read_state  = 1'b0;
        ds_temperature = 9'd0;
        for (int i = 0; i < 3; i++) step();
        check_reset_outputs("rst");

        rst_n  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) txn(vecs[i]);
        expect_idle(1'b0);

        // One-shot request from IDLE, then a request during WAIT_CONV.
        force_req = 1'b1;
        step();
        force_req = 1'b0;
        check("force_start", {31'd0, ds_start}, 32'd1);
        txn(vecs[6]);
        expect_idle(1'b1);

        // Run until the sample counter wraps.
        enable = 1'b1;
        begin
            int remaining;
            remaining = 256 - int'(exp_cnt);
            for (int i = 0; i < remaining; i++) begin
                vec_t v;
                v = '{temp: 9'($urandom_range(0, 511)), rise: 1, fall: 2,
                      en_off: -1, accept: 1'b1, gap_chk: (i > 0)};
                txn(v);
            end
        end
        check("wrap_cnt", {24'd0, sample_cnt}, 32'd0);

        // Reset while the controller is reading.
        wait_start(1'b1, ok);
        if (ok) begin
            step();
            ds_read_state = 1'b1;
            step();
            step();
            rst_n = 1'b0;
            step();
            check_reset_outputs("midrst");
            ds_read_state = 1'b0;
            m_temp  = 9'd0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            exp_cnt = 8'd0;
            step();
            rst_n = 1'b1;
            txn('{temp: 9'h0C3, rise: 2, fall: 5, en_off: -1, accept: 1'b0, gap_chk: 1'b0});
            txn('{temp: 9'h019, rise: 2, fall: 5, en_off: 3, accept: 1'b1, gap_chk: 1'b1});
            check("final_cnt", {24'd0, sample_cnt}, 32'd1);
        end
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
